// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: pipeline port 0 and a FIFO-buffered multi-cycle port 1 share one
// register-file write port. Define WB_ARB_STARVE_EN to let a starved FIFO head force a win.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  input  logic [4:0]  p0_addr,
  input  logic [31:0] p0_data,
  output logic        p0_ready,
  input  logic        p1_valid,
  input  logic [4:0]  p1_addr,
  input  logic [31:0] p1_data,
  output logic        p1_ready,
  output logic [4:0]  writereg,
  output logic [31:0] writedata,
  output logic        regwrite,
  output logic [31:0] busy_mask
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // p0_ready depends combinationally on p0_valid; p1_ready depends only on registered state.

  logic [PW-1:0] wr_ptr, rd_ptr, fill;
  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic          empty, full, push, fifo_sel, starve;
  logic          out_valid;
  logic [4:0]    out_addr;
  logic [31:0]   out_data;
  logic [31:0]   pend;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign fill  = wr_ptr - rd_ptr;

`ifdef WB_ARB_STARVE_EN
  logic [7:0] starve_cnt;

  assign starve = (starve_cnt == 8'(STARVE_LIMIT));

  // Counts only cycles where the FIFO holds data and port 0 took the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    starve_cnt <= '0;
    else if (empty || fifo_sel) starve_cnt <= '0;
    else if (!starve)           starve_cnt <= starve_cnt + 8'd1;
  end
`else
  assign starve = 1'b0;
`endif

  assign fifo_sel = !empty && (!p0_valid || starve);
  assign push     = p1_valid && !full;
  assign p0_ready = !fifo_sel;
  assign p1_ready = !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PW'(1);
      if (fifo_sel) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry payload needs no reset: validity is carried by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[AW-1:0]] <= p1_addr;
      fifo_data[wr_ptr[AW-1:0]] <= p1_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (fifo_sel) begin
      out_valid <= 1'b1;
      out_addr  <= fifo_addr[rd_ptr[AW-1:0]];
      out_data  <= fifo_data[rd_ptr[AW-1:0]];
    end else if (p0_valid) begin
      out_valid <= 1'b1;
      out_addr  <= p0_addr;
      out_data  <= p0_data;
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign writereg  = out_addr;
  assign writedata = out_data;
  assign regwrite  = out_valid && (out_addr != 5'd0);

  always_comb begin
    pend = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (PW'(k) < fill) pend[fifo_addr[rd_ptr[AW-1:0] + AW'(k)]] = 1'b1;
    end
    if (out_valid) pend[out_addr] = 1'b1;
    busy_mask = {pend[31:1], 1'b0};
  end

endmodule
